// File: rtl/gat_load_sequencer.sv
// Load-and-run sequencer: steers one 32-bit word stream into four accelerator BRAM write ports, then waits for gat_ready.
// Optional LOAD_PERF_CNT_EN adds perf_cycles, a saturating LD_SG-to-DONE cycle counter.
module gat_load_sequencer #(
    parameter int unsigned TOP_WIDTH        = 32,
    parameter int unsigned SG_DEPTH         = 13264,
    parameter int unsigned H_DATA_DEPTH     = 242101,
    parameter int unsigned NODE_INFO_DEPTH  = 13264,
    parameter int unsigned WEIGHT_DEPTH     = 22928,
    parameter int unsigned SG_ADDR_W        = $clog2(SG_DEPTH),
    parameter int unsigned H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
    parameter int unsigned NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
    parameter int unsigned WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [TOP_WIDTH-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [TOP_WIDTH-1:0]          subgraph_bram_din,
    output logic                          subgraph_bram_ena,
    output logic                          subgraph_bram_wea,
    output logic [SG_ADDR_W+1:0]          subgraph_bram_addra,
    output logic [TOP_WIDTH-1:0]          h_data_bram_din,
    output logic                          h_data_bram_ena,
    output logic                          h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra,
    output logic [TOP_WIDTH-1:0]          h_node_info_bram_din,
    output logic                          h_node_info_bram_ena,
    output logic                          h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0]          wgt_bram_din,
    output logic                          wgt_bram_ena,
    output logic                          wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra,
    output logic                          h_data_bram_load_done,
    output logic                          h_node_info_bram_load_done,
    output logic                          wgt_bram_load_done,
    input  logic                          gat_ready,
    output logic                          busy,
    output logic                          done,
    output logic [2:0]                    seq_state
`ifdef LOAD_PERF_CNT_EN
    ,
    output logic [TOP_WIDTH-1:0]          perf_cycles
`endif
);

    localparam int unsigned MAX_A = (SG_ADDR_W > H_DATA_ADDR_W) ? SG_ADDR_W : H_DATA_ADDR_W;
    localparam int unsigned MAX_B = (NODE_INFO_ADDR_W > WEIGHT_ADDR_W) ? NODE_INFO_ADDR_W : WEIGHT_ADDR_W;
    localparam int unsigned CNT_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_SG = 3'd1,
        LD_H  = 3'd2,
        LD_NI = 3'd3,
        LD_W  = 3'd4,
        RUN   = 3'd5,
        DONE  = 3'd6
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         s_ready_q, s_ready_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         armed_q, armed_d;
    logic [2:0]                   flags_q, flags_d;   // {wgt, node_info, h_data}
    logic [2:0]                   fin_q, fin_d;       // final write of a flagged region in flight
    logic [3:0]                   we_q, we_d;         // {wgt, node_info, h_data, subgraph}
    logic [TOP_WIDTH-1:0]         sg_din_q, sg_din_d, h_din_q, h_din_d;
    logic [TOP_WIDTH-1:0]         ni_din_q, ni_din_d, w_din_q, w_din_d;
    logic [SG_ADDR_W+1:0]         sg_addr_q, sg_addr_d;
    logic [H_DATA_ADDR_W+1:0]     h_addr_q, h_addr_d;
    logic [NODE_INFO_ADDR_W+1:0]  ni_addr_q, ni_addr_d;
    logic [WEIGHT_ADDR_W+1:0]     w_addr_q, w_addr_d;
    logic                         hs;
    logic                         cnt_last;
    logic                         adv;

    // abort masks a handshake so nothing is launched in the abort cycle
    assign hs = s_valid & s_ready_q & ~abort;

    always_comb begin
        cnt_last = 1'b0;
        case (state_q)
            LD_SG:   cnt_last = (cnt_q == CNT_W'(SG_DEPTH - 1));
            LD_H:    cnt_last = (cnt_q == CNT_W'(H_DATA_DEPTH - 1));
            LD_NI:   cnt_last = (cnt_q == CNT_W'(NODE_INFO_DEPTH - 1));
            LD_W:    cnt_last = (cnt_q == CNT_W'(WEIGHT_DEPTH - 1));
            default: cnt_last = 1'b0;
        endcase
    end

    // next-state, counter, flags and write-port steering
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adv      = 1'b0;
        armed_d  = 1'b0;
        done_d   = 1'b0;
        flags_d  = flags_q | fin_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            flags_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = LD_SG;
                        cnt_d   = '0;
                        flags_d = '0;
                    end
                end
                LD_SG, LD_H, LD_NI, LD_W: begin
                    if (hs) begin
                        if (cnt_last) begin
                            cnt_d   = '0;
                            adv     = 1'b1;
                            state_d = state_e'(state_q + 3'd1);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    armed_d = 1'b1;
                    if (armed_q && gat_ready) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        fin_d     = {adv & (state_q == LD_W), adv & (state_q == LD_NI), adv & (state_q == LD_H)};
        s_ready_d = ~adv & (state_d inside {LD_SG, LD_H, LD_NI, LD_W});
        busy_d    = ~((state_d == IDLE) || (state_d == DONE));

        we_d      = {hs & (state_q == LD_W), hs & (state_q == LD_NI),
                     hs & (state_q == LD_H), hs & (state_q == LD_SG)};
        sg_din_d  = we_d[0] ? s_data : sg_din_q;
        h_din_d   = we_d[1] ? s_data : h_din_q;
        ni_din_d  = we_d[2] ? s_data : ni_din_q;
        w_din_d   = we_d[3] ? s_data : w_din_q;
        sg_addr_d = we_d[0] ? {cnt_q[SG_ADDR_W-1:0], 2'b00} : sg_addr_q;
        h_addr_d  = we_d[1] ? {cnt_q[H_DATA_ADDR_W-1:0], 2'b00} : h_addr_q;
        ni_addr_d = we_d[2] ? {cnt_q[NODE_INFO_ADDR_W-1:0], 2'b00} : ni_addr_q;
        w_addr_d  = we_d[3] ? {cnt_q[WEIGHT_ADDR_W-1:0], 2'b00} : w_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            armed_q   <= 1'b0;
            flags_q   <= '0;
            fin_q     <= '0;
            we_q      <= '0;
            sg_din_q  <= '0;
            h_din_q   <= '0;
            ni_din_q  <= '0;
            w_din_q   <= '0;
            sg_addr_q <= '0;
            h_addr_q  <= '0;
            ni_addr_q <= '0;
            w_addr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            armed_q   <= armed_d;
            flags_q   <= flags_d;
            fin_q     <= fin_d;
            we_q      <= we_d;
            sg_din_q  <= sg_din_d;
            h_din_q   <= h_din_d;
            ni_din_q  <= ni_din_d;
            w_din_q   <= w_din_d;
            sg_addr_q <= sg_addr_d;
            h_addr_q  <= h_addr_d;
            ni_addr_q <= ni_addr_d;
            w_addr_q  <= w_addr_d;
        end
    end

`ifdef LOAD_PERF_CNT_EN
    logic [TOP_WIDTH-1:0] perf_q, perf_d;

    // counts every cycle spent in LD_SG..RUN, saturating
    always_comb begin
        perf_d = perf_q;
        if (abort || (((state_q == IDLE) || (state_q == DONE)) && start)) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_d = perf_q + TOP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

    assign s_ready                    = s_ready_q;
    assign busy                       = busy_q;
    assign done                       = done_q;
    assign seq_state                  = state_q;
    assign h_data_bram_load_done      = flags_q[0];
    assign h_node_info_bram_load_done = flags_q[1];
    assign wgt_bram_load_done         = flags_q[2];
    assign subgraph_bram_din          = sg_din_q;
    assign subgraph_bram_ena          = we_q[0];
    assign subgraph_bram_wea          = we_q[0];
    assign subgraph_bram_addra        = sg_addr_q;
    assign h_data_bram_din            = h_din_q;
    assign h_data_bram_ena            = we_q[1];
    assign h_data_bram_wea            = we_q[1];
    assign h_data_bram_addra          = h_addr_q;
    assign h_node_info_bram_din       = ni_din_q;
    assign h_node_info_bram_ena       = we_q[2];
    assign h_node_info_bram_wea       = we_q[2];
    assign h_node_info_bram_addra     = ni_addr_q;
    assign wgt_bram_din               = w_din_q;
    assign wgt_bram_ena               = we_q[3];
    assign wgt_bram_wea               = we_q[3];
    assign wgt_bram_addra             = w_addr_q;

endmodule

// File: tb/tb_gat_load_sequencer.sv
// Bench for gat_load_sequencer with small depths: a word table feeds a write scoreboard, plus hand sequences
// for RUN/DONE, abort, ignored start and asynchronous reset.
module tb_gat_load_sequencer;

    localparam int unsigned TW  = 32;
    localparam int unsigned SGD = 2;
    localparam int unsigned HD  = 4;
    localparam int unsigned NID = 3;
    localparam int unsigned WD  = 5;
    localparam int unsigned SGA = $clog2(SGD) + 2;
    localparam int unsigned HA  = $clog2(HD) + 2;
    localparam int unsigned NIA = $clog2(NID) + 2;
    localparam int unsigned WA  = $clog2(WD) + 2;
    localparam int NWORDS = 14;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start, abort, s_valid, s_ready, gat_ready;
    logic [TW-1:0]  s_data;
    logic [TW-1:0]  sg_din, h_din, ni_din, w_din;
    logic           sg_ena, sg_wea, h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea;
    logic [SGA-1:0] sg_addr;
    logic [HA-1:0]  h_addr;
    logic [NIA-1:0] ni_addr;
    logic [WA-1:0]  w_addr;
    logic           h_flag, ni_flag, w_flag, busy, done;
    logic [2:0]     seq_state;
`ifdef LOAD_PERF_CNT_EN
    logic [TW-1:0]  perf_cycles;
`endif

    gat_load_sequencer #(
        .TOP_WIDTH(TW), .SG_DEPTH(SGD), .H_DATA_DEPTH(HD),
        .NODE_INFO_DEPTH(NID), .WEIGHT_DEPTH(WD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .subgraph_bram_din(sg_din), .subgraph_bram_ena(sg_ena),
        .subgraph_bram_wea(sg_wea), .subgraph_bram_addra(sg_addr),
        .h_data_bram_din(h_din), .h_data_bram_ena(h_ena),
        .h_data_bram_wea(h_wea), .h_data_bram_addra(h_addr),
        .h_node_info_bram_din(ni_din), .h_node_info_bram_ena(ni_ena),
        .h_node_info_bram_wea(ni_wea), .h_node_info_bram_addra(ni_addr),
        .wgt_bram_din(w_din), .wgt_bram_ena(w_ena),
        .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addr),
        .h_data_bram_load_done(h_flag), .h_node_info_bram_load_done(ni_flag),
        .wgt_bram_load_done(w_flag), .gat_ready(gat_ready),
        .busy(busy), .done(done), .seq_state(seq_state)
`ifdef LOAD_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          port;
        int          idx;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    vec_t       vec [NWORDS];
    exp_t       q [$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         hs_cyc [NWORDS];
    int         h_rise, ni_rise, w_rise;
    int         busy_cnt;
    logic [2:0] flags_prev = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_port(input int p, input logic en, input logic we,
                              input logic [31:0] addr, input logic [31:0] din);
        exp_t e;
        if (en || we) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: port %0d addr %0h data %0h, no write expected (cycle %0d)",
                         p, addr, din, cyc);
            end else begin
                e = q.pop_front();
                chk("wr_port", 32'(p), 32'(e.port));
                chk("wr_ena_wea", {30'b0, en, we}, 32'h3);
                chk("wr_addr", addr, e.addr);
                chk("wr_data", din, e.data);
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    // advance one clock and observe outputs 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (busy) busy_cnt++;
        check_port(0, sg_ena, sg_wea, 32'(sg_addr), sg_din);
        check_port(1, h_ena,  h_wea,  32'(h_addr),  h_din);
        check_port(2, ni_ena, ni_wea, 32'(ni_addr), ni_din);
        check_port(3, w_ena,  w_wea,  32'(w_addr),  w_din);
        if (h_flag  && !flags_prev[0]) h_rise  = cyc;
        if (ni_flag && !flags_prev[1]) ni_rise = cyc;
        if (w_flag  && !flags_prev[2]) w_rise  = cyc;
        flags_prev = {w_flag, ni_flag, h_flag};
    endtask

    task automatic do_start();
        h_rise = -1; ni_rise = -1; w_rise = -1;
        busy_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_stream(input bit toggle, input bit start_mid, input int nwords);
        int   k = 0;
        int   budget = 0;
        exp_t e;
        while (k < nwords && budget < 200) begin
            s_valid = toggle ? ((budget % 2) == 0) : 1'b1;
            s_data  = vec[k].data;
            start   = start_mid && (k == 7);
            if (s_valid && s_ready) begin
                e.port = vec[k].port;
                e.addr = 32'(vec[k].idx * 4);
                e.data = vec[k].data;
                e.cyc  = cyc + 1;
                q.push_back(e);
                hs_cyc[k] = cyc;
                k++;
            end
            tick();
            budget++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk("stream_words_accepted", 32'(k), 32'(nwords));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_cnt;
        for (int k = 0; k < NWORDS; k++) begin
            vec[k].data = 32'(k);
            if (k < 2)      begin vec[k].port = 0; vec[k].idx = k;     end
            else if (k < 6) begin vec[k].port = 1; vec[k].idx = k - 2; end
            else if (k < 9) begin vec[k].port = 2; vec[k].idx = k - 6; end
            else            begin vec[k].port = 3; vec[k].idx = k - 9; end
        end
        start = 0; abort = 0; s_valid = 0; s_data = 0; gat_ready = 0;
        busy_cnt = 0; h_rise = -1; ni_rise = -1; w_rise = -1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_state", 32'(seq_state), 32'd0);
        chk("rst_ready_busy_done", {29'b0, s_ready, busy, done}, 32'd0);
        chk("rst_flags", {29'b0, w_flag, ni_flag, h_flag}, 32'd0);
        chk("rst_strobes", {28'b0, w_ena, ni_ena, h_ena, sg_ena}, 32'd0);
        chk("rst_din_or", sg_din | h_din | ni_din | w_din, 32'd0);
`ifdef LOAD_PERF_CNT_EN
        chk("rst_perf", perf_cycles, 32'd0);
`endif
        rst_n = 1'b1;
        tick(); tick();

        // back-to-back load of words 0..13
        do_start();
        chk("start_state", 32'(seq_state), 32'd1);
        chk("start_ready_busy", {30'b0, s_ready, busy}, 32'h3);
        load_stream(1'b0, 1'b0, NWORDS);
        tick(); tick();
        chk("s1_queue_drained", 32'(q.size()), 32'd0);
        chk("s1_sg_back_to_back", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
        chk("s1_bubble_sg_h", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
        chk("s1_total_span", 32'(hs_cyc[13] - hs_cyc[0]), 32'd16);
        chk("s1_h_flag_rise", 32'(h_rise), 32'(hs_cyc[5] + 2));
        chk("s1_ni_flag_rise", 32'(ni_rise), 32'(hs_cyc[8] + 2));
        chk("s1_w_flag_rise", 32'(w_rise), 32'(hs_cyc[13] + 2));
        chk("s1_run_state", 32'(seq_state), 32'd5);
        chk("s1_run_ready_busy", {30'b0, s_ready, busy}, 32'h1);
        run_cnt = 0;
        repeat (20) begin
            tick();
            if (seq_state == 3'd5 && !done) run_cnt++;
        end
        chk("s1_run_hold_cycles", 32'(run_cnt), 32'd20);
        gat_ready = 1'b1;
        tick();
        gat_ready = 1'b0;
        chk("s1_done_state", 32'(seq_state), 32'd6);
        chk("s1_done_busy", {30'b0, done, busy}, 32'h2);
        chk("s1_flags_held", {29'b0, w_flag, ni_flag, h_flag}, 32'h7);
`ifdef LOAD_PERF_CNT_EN
        chk("s1_perf_cycles", perf_cycles, 32'(busy_cnt));
`endif
        tick();
        chk("s1_done_pulse_end", {31'b0, done}, 32'd0);
        chk("s1_done_holds", 32'(seq_state), 32'd6);
        chk("s1_flags_in_done", {29'b0, w_flag, ni_flag, h_flag}, 32'h7);

        // restart from DONE, gapped stream, start pulsed in LD_NI
        for (int k = 0; k < NWORDS; k++) vec[k].data = $urandom;
        do_start();
        chk("s2_flags_cleared", {29'b0, w_flag, ni_flag, h_flag}, 32'd0);
        chk("s2_state", 32'(seq_state), 32'd1);
        load_stream(1'b1, 1'b1, NWORDS);
        gat_ready = 1'b1;
        tick();
        chk("s2_first_run_cycle_ignores_ready", 32'(seq_state), 32'd5);
        tick();
        gat_ready = 1'b0;
        chk("s2_done_state", 32'(seq_state), 32'd6);
        chk("s2_done_pulse", {31'b0, done}, 32'd1);
        chk("s2_queue_drained", 32'(q.size()), 32'd0);

        // abort after the third H word, with a word offered in the abort cycle
        for (int k = 0; k < NWORDS; k++) vec[k].data = 32'(k);
        do_start();
        load_stream(1'b0, 1'b0, 5);
        abort = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        tick();
        abort = 1'b0; s_valid = 1'b0;
        chk("abort_state", 32'(seq_state), 32'd0);
        chk("abort_ready_busy", {30'b0, s_ready, busy}, 32'd0);
        chk("abort_flags", {29'b0, w_flag, ni_flag, h_flag}, 32'd0);
        tick(); tick();
        chk("abort_no_write", 32'(q.size()), 32'd0);

        // reload from SG address 0, then async reset mid LD_W
        do_start();
        load_stream(1'b0, 1'b0, 11);
        chk("pre_reset_state", 32'(seq_state), 32'd4);
        chk("pre_reset_flags", {29'b0, w_flag, ni_flag, h_flag}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_state", 32'(seq_state), 32'd0);
        chk("areset_ready_busy_done", {29'b0, s_ready, busy, done}, 32'd0);
        chk("areset_flags", {29'b0, w_flag, ni_flag, h_flag}, 32'd0);
        chk("areset_strobes", {28'b0, w_ena, ni_ena, h_ena, sg_ena}, 32'd0);
        chk("areset_queue", 32'(q.size()), 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("post_reset_idle", 32'(seq_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gat_load_sequencer.md
Name: gat_load_sequencer

Overview:
- Controller that sequences the accelerator's load-and-run flow from a single 32-bit valid/ready word stream.
- Steers consecutive words into the subgraph-index, H-data, node-info and weight BRAM write ports in fixed order, generating byte addresses and write strobes.
- Raises the per-BRAM load-done flags and waits for gat_ready, then reports completion.
- Sits between the host DMA/stream interconnect and the accelerator top wrapper.

Parameters:
- TOP_WIDTH, 32, stream and BRAM data width.
- SG_DEPTH, 13264, subgraph-index words to load.
- H_DATA_DEPTH, 242101, H sparse-data words to load.
- NODE_INFO_DEPTH, 13264, node-info words to load.
- WEIGHT_DEPTH, 22928, weight words to load.
- SG_ADDR_W, $clog2(SG_DEPTH), word-address width; H_DATA_ADDR_W, NODE_INFO_ADDR_W and WEIGHT_ADDR_W are defined the same way from their depths.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load/run sequence
- abort  in  1  synchronous clear to IDLE
- s_data  in  TOP_WIDTH  stream word
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- subgraph_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/SG_ADDR_W+2  subgraph BRAM write port
- h_data_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/H_DATA_ADDR_W+2  H-data BRAM write port
- h_node_info_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/NODE_INFO_ADDR_W+2  node-info BRAM write port
- wgt_bram_din/ena/wea/addra  out  TOP_WIDTH/1/1/WEIGHT_ADDR_W+2  weight BRAM write port
- h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done  out  1 each  sticky load-complete flags
- gat_ready  in  1  accelerator finished
- busy  out  1  high in any state other than IDLE and DONE
- done  out  1  one-cycle completion pulse
- seq_state  out  3  current state encoding, for debug

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter 0.
- State encodings: IDLE=0, LD_SG=1, LD_H=2, LD_NI=3, LD_W=4, RUN=5, DONE=6.
- IDLE/DONE: start -> LD_SG. On entry from start, counter and all three load-done flags are cleared. start is ignored in every other state.
- Load states:
  - s_ready=1 only in LD_SG, LD_H, LD_NI and LD_W.
  - A handshake is s_valid & s_ready. Each handshake writes counter++.
  - On the cycle after a handshake, the selected BRAM port drives din=s_data, ena=wea=1, addra={counter,2'b00}. This is 1-cycle registered latency.
  - All other ports drive ena=wea=0. Each port holds its din/addra between writes.
  - Handshake when counter==DEPTH-1 for the current state: counter->0 and advance to LD_H, LD_NI, LD_W, then RUN in turn. s_ready drops for exactly one cycle on each transition (bubble).
- Load-done flags: LD_H, LD_NI and LD_W each set their flag one cycle after their final BRAM write strobe, i.e. two cycles after the final handshake. The flag holds until the next start or abort. LD_SG has no flag.
- RUN:
  - Waits for gat_ready==1. gat_ready is sampled only after at least one cycle in RUN.
  - On gat_ready -> DONE with done=1 for that single cycle. busy=0 in DONE.
- s_valid low in a load state: stall. Counter and outputs hold; no strobes.
- abort: highest priority in any state. The next state is IDLE; counter, flags, strobes and s_ready go to 0. Any in-flight registered write is suppressed.
- start and abort in the same cycle: abort wins.
- Async reset mid-operation: everything returns to reset values immediately; no write strobe is issued.
- No data is consumed in RUN, DONE or IDLE (s_ready=0).

Optional Feature:
- Macro LOAD_PERF_CNT_EN.
- When defined, adds an output perf_cycles (TOP_WIDTH). It counts clk cycles from entry to LD_SG until entry to DONE, and saturates at all-ones. It is cleared on start and abort, and holds its value in DONE and IDLE.
- When undefined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- Depths overridden to SG=2, H=4, NI=3, W=5. start, then 14 back-to-back words 0..13 -> SG writes addr 0,4 with data 0,1; H writes addr 0..12 with data 2..5; NI writes data 6..8; W writes data 9..13. Each write appears one cycle after its handshake, with one s_ready bubble per transition. h_data_bram_load_done rises two cycles after word 5 is accepted.
- Same run with s_valid toggling every other cycle -> identical BRAM contents and addresses; no strobes on idle cycles.
- After all loads, hold gat_ready=0 for 20 cycles, then pulse it high -> state RUN for 20 cycles; done=1 for exactly 1 cycle; busy falls; the three flags stay 1.
- abort asserted after the third H word -> IDLE next cycle, flags 0, s_ready 0. A following start reloads from SG address 0.
- start pulsed during LD_NI -> ignored; sequence completes normally. start in DONE -> flags clear and LD_SG begins.
- rst_n asserted low asynchronously mid LD_W -> all outputs 0 without waiting for a clock edge. With LOAD_PERF_CNT_EN defined, the first scenario yields perf_cycles equal to the measured LD_SG-to-DONE cycle count.
